spi_filter_top: RTL and testbench
=================================

SPI_FILTER_TOP -- requirements
Module: spi_filter_top

Interface
REQ-001 Parameter FILTER_LEN, default 4: consecutive equal clk_in samples required before a filtered input changes level.
REQ-002 Parameter FRAME_BITS, default 8: bit count for a valid frame.
REQ-003 clk_in  input  1  system clock, 25 MHz (40 ns); sole clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 spi_cs  input  1  SPI chip select, active-low, asynchronous to clk_in.
REQ-006 spi_sck  input  1  SPI clock (mode 0), asynchronous to clk_in.
REQ-007 spi_mosi  input  1  SPI data in, MSB first.
REQ-008 spi_miso  output  1  SPI data out.
REQ-009 led  output  2  active-low status LEDs: led[1] green = integrity OK, led[0] red = integrity error.

Function
REQ-010 spi_cs, spi_sck and spi_mosi shall each pass through a 2-flop synchronizer.
REQ-011 Each synchronized input shall feed a FILTER_LEN-deep shift register; the filtered level shall change only when all FILTER_LEN samples equal the new level, otherwise it holds.
REQ-012 A level shorter than FILTER_LEN clocks (under 160 ns at defaults) shall never change a filtered signal.
REQ-013 Input-to-filtered latency: 2 sync cycles plus FILTER_LEN cycles (6 cycles at defaults).
REQ-014 Edge detection shall operate on filtered signals only: sck_rise, cs_fall, cs_rise, each a one-cycle pulse.
REQ-015 On cs_fall: bit_cnt cleared to 0; shift register loaded with tx_byte (last completed rx byte).
REQ-016 On sck_rise while filtered CS is low: filtered MOSI shifted into rx_shift LSB; bit_cnt incremented, saturating at 15 (4 bits).
REQ-017 spi_miso shall drive the tx shift MSB while filtered CS is low; it advances one bit on each filtered SCK falling edge; it drives 0 while CS is high.
REQ-018 On cs_rise, if bit_cnt == FRAME_BITS: led = 2'b01 (green on, red off); rx_shift copied to tx_byte.
REQ-019 On cs_rise, if bit_cnt != FRAME_BITS (including 0): led = 2'b10 (red on, green off); tx_byte unchanged.
REQ-020 led shall hold its value until the next cs_rise or reset.
REQ-021 sck_rise while CS is high shall be ignored.
REQ-022 If cs_rise and sck_rise coincide, the audit shall use the bit_cnt value before the increment.

Reset
REQ-023 While rst = 0, asynchronously: all synchronizer and filter flops set to idle (CS = 1, SCK = 0, MOSI = 0); bit_cnt = 0; rx_shift = 0; tx_byte = 0; spi_miso = 0; led = 2'b11 (both off).
REQ-024 Reset mid-frame shall discard the frame and produce no audit; the first post-reset frame starts only on a fresh filtered CS fall.

Structure
REQ-025 A shared package spi_filter_pkg shall hold FILTER_LEN, FRAME_BITS, the bit_cnt width (4) and the LED encodings LED_OK = 2'b01, LED_ERR = 2'b10, LED_OFF = 2'b11.
REQ-026 One sub-module, glitch_filter (sync + FILTER_LEN filter, parameterized by reset value), shall be instantiated three times.

Verification
REQ-027 One valid bit, then a 20 ns SCK glitch, then CS high -> bit_cnt = 1 (not 2); led = 2'b10.
REQ-028 8 stable SCK pulses (400 ns high/low) shifting 0xA5, then CS high -> bit_cnt = 8; led = 2'b01; tx_byte = 0xA5.
REQ-029 Next frame, 8 clocks -> spi_miso emits 1,0,1,0,0,1,0,1 on successive SCK rises.
REQ-030 SCK pulse of exactly 3 clk_in cycles -> ignored; pulse of 5 cycles -> counted.
REQ-031 20 ns glitch on CS during a frame -> frame continues; no audit; LEDs unchanged.
REQ-032 rst asserted after 4 bits -> led = 2'b11; bit_cnt = 0; a following 8-bit frame -> led = 2'b01.

Source files
------------

// File: rtl/spi_filter_pkg.sv
// Shared constants and types for the filtered SPI receiver and its integrity LEDs.
package spi_filter_pkg;

    localparam int FILTER_LEN = 4;
    localparam int FRAME_BITS = 8;
    localparam int CNT_W      = 4;
    localparam int BYTE_W     = 8;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        LED_OK  = 2'b01,
        LED_ERR = 2'b10,
        LED_OFF = 2'b11
    } led_e;

    typedef struct packed {
        logic rise;
        logic fall;
    } edge_t;

    function automatic edge_t detectEdge(input logic cur, input logic prev);
        edge_t e;
        e.rise = cur & ~prev;
        e.fall = ~cur & prev;
        return e;
    endfunction

endpackage

// File: rtl/spi_filter_if.sv
// SPI pins plus the status LEDs, bundled so the bench and the filter share one bus.
interface spi_filter_if;

    logic       spi_cs;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso;
    logic [1:0] led;

    modport master (
        output spi_cs,
        output spi_sck,
        output spi_mosi,
        input  spi_miso,
        input  led
    );

    modport slave (
        input  spi_cs,
        input  spi_sck,
        input  spi_mosi,
        output spi_miso,
        output led
    );

endinterface

// File: rtl/spi_filter_glitch_filter.sv
// Two-flop synchronizer followed by a level filter that only moves once
// FILTER_LEN consecutive samples agree on the new level.
module glitch_filter #(
    parameter int   FILTER_LEN = 4,
    parameter logic RESET_VAL  = 1'b0
) (
    input  logic clk_in,
    input  logic rst,
    input  logic i_async,
    output logic o_level
);

    logic [1:0]            r_sync;
    logic [FILTER_LEN-1:0] r_hist;
    logic                  r_level;
    logic [FILTER_LEN-1:0] w_histNext;

    // The incoming sample takes part in the vote so the level moves on the
    // same edge the last required sample arrives.
    assign w_histNext = {r_hist[FILTER_LEN-2:0], r_sync[1]};

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_sync  <= {2{RESET_VAL}};
            r_hist  <= {FILTER_LEN{RESET_VAL}};
            r_level <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[0], i_async};
            r_hist <= w_histNext;
            if (&w_histNext) begin
                r_level <= 1'b1;
            end else if (~|w_histNext) begin
                r_level <= 1'b0;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/spi_filter_top.sv
// Mode-0 SPI slave on glitch-filtered pins; audits each frame's bit count on
// CS release and echoes the last good byte back on MISO during the next frame.
module spi_filter_top #(
    parameter int FILTER_LEN = spi_filter_pkg::FILTER_LEN,
    parameter int FRAME_BITS = spi_filter_pkg::FRAME_BITS
) (
    input  logic          clk_in,
    input  logic          rst,
    spi_filter_if.slave   spi_bus
);

    import spi_filter_pkg::*;

    logic              w_csFilt;
    logic              w_sckFilt;
    logic              w_mosiFilt;
    edge_t             w_csEdge;
    edge_t             w_sckEdge;

    logic              r_csPrev;
    logic              r_sckPrev;
    logic [CNT_W-1:0]  r_bitCnt;
    logic [BYTE_W-1:0] r_rxShift;
    logic [BYTE_W-1:0] r_txShift;
    logic [BYTE_W-1:0] r_txByte;
    led_e              r_led;

    glitch_filter #(.FILTER_LEN(FILTER_LEN), .RESET_VAL(1'b1)) u_csFilter (
        .clk_in  (clk_in),
        .rst     (rst),
        .i_async (spi_bus.spi_cs),
        .o_level (w_csFilt)
    );

    glitch_filter #(.FILTER_LEN(FILTER_LEN), .RESET_VAL(1'b0)) u_sckFilter (
        .clk_in  (clk_in),
        .rst     (rst),
        .i_async (spi_bus.spi_sck),
        .o_level (w_sckFilt)
    );

    glitch_filter #(.FILTER_LEN(FILTER_LEN), .RESET_VAL(1'b0)) u_mosiFilter (
        .clk_in  (clk_in),
        .rst     (rst),
        .i_async (spi_bus.spi_mosi),
        .o_level (w_mosiFilt)
    );

    assign w_csEdge  = detectEdge(w_csFilt, r_csPrev);
    assign w_sckEdge = detectEdge(w_sckFilt, r_sckPrev);

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_csPrev  <= 1'b1;
            r_sckPrev <= 1'b0;
            r_bitCnt  <= '0;
            r_rxShift <= '0;
            r_txShift <= '0;
            r_txByte  <= '0;
            r_led     <= LED_OFF;
        end else begin
            r_csPrev  <= w_csFilt;
            r_sckPrev <= w_sckFilt;

            if (w_csEdge.fall) begin
                r_bitCnt  <= '0;
                r_txShift <= r_txByte;
            end else if (!w_csFilt) begin
                if (w_sckEdge.rise) begin
                    r_rxShift <= {r_rxShift[BYTE_W-2:0], w_mosiFilt};
                    if (r_bitCnt != CNT_MAX) begin
                        r_bitCnt <= r_bitCnt + CNT_W'(1);
                    end
                end
                if (w_sckEdge.fall) begin
                    r_txShift <= {r_txShift[BYTE_W-2:0], 1'b0};
                end
            end

            // A coinciding SCK rise is already masked by CS being high here,
            // so the audit sees the pre-increment count.
            if (w_csEdge.rise) begin
                if (r_bitCnt == CNT_W'(FRAME_BITS)) begin
                    r_led    <= LED_OK;
                    r_txByte <= r_rxShift;
                end else begin
                    r_led    <= LED_ERR;
                end
            end
        end
    end

    assign spi_bus.spi_miso = w_csFilt ? 1'b0 : r_txShift[BYTE_W-1];
    assign spi_bus.led      = r_led;

endmodule

// File: tb/tb_spi_filter_top.sv
// Scoreboard bench for spi_filter_top: frames, glitches, short pulses and mid-frame reset.
module tb_spi_filter_top;

    logic clk_in = 1'b0;
    logic rst    = 1'b0;

    always #20 clk_in = ~clk_in;

    spi_filter_if spiBus ();

    spi_filter_top #(.FILTER_LEN(4), .FRAME_BITS(8)) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .spi_bus (spiBus)
    );

    int         testsRun    = 0;
    int         testsFailed = 0;
    logic [7:0] expQ[$];
    string      tagQ[$];
    logic [7:0] modelTx  = 8'h00;
    logic [1:0] modelLed = 2'b11;

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, actual, expected);
        end
    endtask

    task automatic pushExp(input string tag, input logic [7:0] value);
        tagQ.push_back(tag);
        expQ.push_back(value);
    endtask

    task automatic popCheck(input logic [7:0] actual);
        if (expQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL scoreboard_underflow: got 0x%02h, expected an entry", actual);
        end else begin
            checkOutput(tagQ.pop_front(), actual, expQ.pop_front());
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // One mode-0 bit: data set while SCK is low, MISO sampled just before the rise.
    task automatic sendBit(input logic b, input int highCycles, input logic [7:0] expMiso);
        pushExp("miso_bit", expMiso);
        spiBus.spi_mosi = b;
        waitCycles(10);
        popCheck({7'b0, spiBus.spi_miso});
        spiBus.spi_sck = 1'b1;
        waitCycles(highCycles);
        spiBus.spi_sck = 1'b0;
    endtask

    task automatic glitchSck();
        @(negedge clk_in);
        #5  spiBus.spi_sck = 1'b1;
        #20 spiBus.spi_sck = 1'b0;
    endtask

    task automatic glitchCs();
        @(negedge clk_in);
        #5  spiBus.spi_cs = 1'b1;
        #20 spiBus.spi_cs = 1'b0;
    endtask

    // Releases CS and audits led, bit count and stored byte against the model.
    task automatic closeFrame(input int expCnt, input logic [7:0] rxByte);
        waitCycles(10);
        spiBus.spi_cs = 1'b1;
        if (expCnt == 8) begin
            modelLed = 2'b01;
            modelTx  = rxByte;
        end else begin
            modelLed = 2'b10;
        end
        pushExp("audit_led", {6'b0, modelLed});
        pushExp("audit_bitcnt", 8'(expCnt));
        pushExp("audit_txbyte", modelTx);
        waitCycles(12);
        popCheck({6'b0, spiBus.led});
        popCheck({4'b0, dut.r_bitCnt});
        popCheck(dut.r_txByte);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input bit csGlitch);
        logic [7:0] txAtStart;
        txAtStart = modelTx;
        @(negedge clk_in);
        spiBus.spi_cs = 1'b0;
        waitCycles(10);
        for (int i = 0; i < 8; i++) begin
            sendBit(data[7-i], 10, {7'b0, txAtStart[7-i]});
            if (csGlitch && i == 3) begin
                glitchCs();
                pushExp("led_hold", {6'b0, modelLed});
                waitCycles(8);
                popCheck({6'b0, spiBus.led});
            end
        end
        closeFrame(8, data);
    endtask

    initial begin
        logic [7:0] txAtStart;
        spiBus.spi_cs   = 1'b1;
        spiBus.spi_sck  = 1'b0;
        spiBus.spi_mosi = 1'b0;
        waitCycles(3);
        pushExp("reset_led", 8'h03);
        pushExp("reset_miso", 8'h00);
        pushExp("reset_bitcnt", 8'h00);
        pushExp("reset_txbyte", 8'h00);
        popCheck({6'b0, spiBus.led});
        popCheck({7'b0, spiBus.spi_miso});
        popCheck({4'b0, dut.r_bitCnt});
        popCheck(dut.r_txByte);
        rst = 1'b1;
        waitCycles(10);

        $display("[TB] one bit followed by an SCK glitch");
        spiBus.spi_cs = 1'b0;
        waitCycles(10);
        sendBit(1'b1, 10, {7'b0, modelTx[7]});
        glitchSck();
        closeFrame(1, 8'h00);

        $display("[TB] full frame 0xA5");
        applyStimulus(8'hA5, 1'b0);

        $display("[TB] frame 0xC3, echo of 0xA5 on MISO");
        applyStimulus(8'hC3, 1'b0);

        $display("[TB] 3-cycle SCK pulse then 5-cycle pulse");
        spiBus.spi_cs = 1'b0;
        waitCycles(10);
        spiBus.spi_sck = 1'b1;
        waitCycles(3);
        spiBus.spi_sck = 1'b0;
        waitCycles(10);
        sendBit(1'b1, 5, {7'b0, modelTx[7]});
        closeFrame(1, 8'h00);

        $display("[TB] CS glitch mid-frame, frame 0x3C");
        applyStimulus(8'h3C, 1'b1);

        $display("[TB] reset after four bits");
        txAtStart = modelTx;
        spiBus.spi_cs = 1'b0;
        waitCycles(10);
        for (int i = 0; i < 4; i++) begin
            sendBit(1'b1, 10, {7'b0, txAtStart[7-i]});
        end
        @(negedge clk_in);
        rst             = 1'b0;
        spiBus.spi_cs   = 1'b1;
        spiBus.spi_mosi = 1'b0;
        modelTx         = 8'h00;
        modelLed        = 2'b11;
        waitCycles(3);
        pushExp("rst_led", 8'h03);
        pushExp("rst_bitcnt", 8'h00);
        pushExp("rst_txbyte", 8'h00);
        pushExp("rst_miso", 8'h00);
        popCheck({6'b0, spiBus.led});
        popCheck({4'b0, dut.r_bitCnt});
        popCheck(dut.r_txByte);
        popCheck({7'b0, spiBus.spi_miso});
        rst = 1'b1;
        waitCycles(12);
        pushExp("post_rst_led", 8'h03);
        popCheck({6'b0, spiBus.led});
        applyStimulus(8'h5A, 1'b0);

        if (expQ.size() != 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL scoreboard_leftover: got %0d entries, expected 0", expQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
